// File: rtl/ysyx_25010030_axi_pkg.sv
// Shared definitions for the AXI read-path blocks.
// Contents:
//   rd_state_e   - arbiter state encoding (IDLE / ADDR / DATA)
//   RESP_*       - AXI RRESP codes used by the arbiter
//   BURST_INCR   - AXI incrementing burst type
//   route_resp() - returns the slave response, or SLVERR when the returned
//                  ID does not belong to the granted master
package ysyx_25010030_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  function automatic logic [1:0] route_resp(input logic i_id_ok, input logic [1:0] i_resp);
    return i_id_ok ? i_resp : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/ysyx_25010030_rr_arb2.sv
// Two-way round-robin picker (purely combinational).
// Ports:
//   i_req0, i_req1 - request valids from requester 0 and 1
//   i_last_grant   - index of the requester served most recently
//   o_valid        - at least one request is present
//   o_grant        - index of the requester to serve next
// A lone requester always wins; on a tie the one not served last wins.
module ysyx_25010030_rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_grant
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    if (i_req0 & i_req1) begin
      o_grant = ~i_last_grant;
    end else begin
      o_grant = i_req1;
    end
  end

endmodule

// File: rtl/ysyx_25010030_axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter (m0 = instruction cache, m1 = LSU)
// in front of a single slave read port. One whole burst is granted at a
// time, the grant is held until the last beat, and ties alternate.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   m0_ar* / m1_ar*       - requester AR channels
//   m0_r*  / m1_r*        - requester R channels (routed beats)
//   s_ar*                 - AR channel towards the slave
//   s_r*                  - R channel from the slave
// All AR/R forwarding is combinational; only state, grant, last grant and
// the requester ID are registered.
module ysyx_25010030_axi_rd_arbiter
  import ysyx_25010030_axi_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  // master 0
  input  logic [31:0]       m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic [ID_W-1:0]   m0_rid,
  output logic              m0_rlast,
  // master 1
  input  logic [31:0]       m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic [ID_W-1:0]   m1_rid,
  output logic              m1_rlast,
  // slave
  output logic [31:0]       s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ID_W-1:0]   s_arid,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic [ID_W-1:0]   s_rid,
  input  logic              s_rlast,
  output logic              s_rready
);

  rd_state_e       r_state;
  logic            r_grant;
  logic            r_last_grant;
  logic [ID_W-1:0] r_saved_id;

  logic       w_pick_valid;
  logic       w_pick;
  logic [1:0] w_resp;
  logic       w_unused_rid;

  // Only bit 0 of the returned ID carries the master index.
  assign w_unused_rid = ^s_rid;

  ysyx_25010030_rr_arb2 u_rr (
    .i_req0       (m0_arvalid),
    .i_req1       (m1_arvalid),
    .i_last_grant (r_last_grant),
    .o_valid      (w_pick_valid),
    .o_grant      (w_pick)
  );

  assign w_resp = route_resp(s_rid[0] == r_grant, s_rresp);

  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_araddr   = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_arvalid  = 1'b0;
    s_arid     = '0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rid     = '0;
    m0_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rid     = '0;
    m1_rlast   = 1'b0;
    case (r_state)
      ST_ADDR: begin
        s_arid = {{(ID_W-1){1'b0}}, r_grant};
        if (r_grant) begin
          s_araddr   = m1_araddr;
          s_arlen    = m1_arlen;
          s_arsize   = m1_arsize;
          s_arburst  = m1_arburst;
          s_arvalid  = m1_arvalid;
          m1_arready = s_arready;
        end else begin
          s_araddr   = m0_araddr;
          s_arlen    = m0_arlen;
          s_arsize   = m0_arsize;
          s_arburst  = m0_arburst;
          s_arvalid  = m0_arvalid;
          m0_arready = s_arready;
        end
      end
      ST_DATA: begin
        if (r_grant) begin
          s_rready  = m1_rready;
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = w_resp;
          m1_rid    = r_saved_id;
          m1_rlast  = s_rlast;
        end else begin
          s_rready  = m0_rready;
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = w_resp;
          m0_rid    = r_saved_id;
          m0_rlast  = s_rlast;
        end
      end
      default: ;
    endcase
  end

  // last_grant resets to 1 so that m0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_saved_id   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant    <= w_pick;
            r_saved_id <= w_pick ? m1_arid : m0_arid;
            r_state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_arvalid & s_arready) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (s_rvalid & s_rready & s_rlast) begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25010030_axi_rd_arbiter.sv
module tb_ysyx_25010030_axi_rd_arbiter;
  import ysyx_25010030_axi_pkg::*;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;
  localparam int OUT_W  = 4 + 2 * (DATA_W + 2 + ID_W + 1) + 32 + 8 + 3 + 2 + 1 + ID_W + 1;

  logic              clk;
  logic              reset_n;
  logic [31:0]       m0_araddr, m1_araddr;
  logic              m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [ID_W-1:0]   m0_arid, m1_arid;
  logic [7:0]        m0_arlen, m1_arlen;
  logic [2:0]        m0_arsize, m1_arsize;
  logic [1:0]        m0_arburst, m1_arburst;
  logic              m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [1:0]        m0_rresp, m1_rresp;
  logic [ID_W-1:0]   m0_rid, m1_rid;
  logic              m0_rlast, m1_rlast;
  logic [31:0]       s_araddr;
  logic [7:0]        s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic              s_arvalid, s_arready;
  logic [ID_W-1:0]   s_arid;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic [ID_W-1:0]   s_rid;
  logic              s_rlast, s_rready;
  logic [OUT_W-1:0]  all_out;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_25010030_axi_rd_arbiter #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rid(m0_rid), .m0_rlast(m0_rlast),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rid(m1_rid), .m1_rlast(m1_rlast),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid),
    .s_rlast(s_rlast), .s_rready(s_rready)
  );

  assign all_out = {m0_arready, m1_arready, m0_rvalid, m1_rvalid,
                    m0_rdata, m0_rresp, m0_rid, m0_rlast,
                    m1_rdata, m1_rresp, m1_rid, m1_rlast,
                    s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_arid, s_rready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_araddr = '0; m0_arvalid = 0; m0_arid = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0;
    m1_araddr = '0; m1_arvalid = 0; m1_arid = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0;
    m0_rready = 0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rid = '0; s_rlast = 0;
  endtask

  task automatic apply_reset;
    reset_n = 0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1;
  endtask

  task automatic req0(input logic [31:0] addr, input logic [7:0] len, input logic [ID_W-1:0] id);
    m0_araddr = addr; m0_arlen = len; m0_arsize = 3'd2; m0_arburst = BURST_INCR;
    m0_arid = id; m0_arvalid = 1; m0_rready = 1;
  endtask

  task automatic req1(input logic [31:0] addr, input logic [7:0] len, input logic [ID_W-1:0] id);
    m1_araddr = addr; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = BURST_INCR;
    m1_arid = id; m1_arvalid = 1; m1_rready = 1;
  endtask

  task automatic test_reset;
    reset_n = 0;
    m0_arvalid = 1; m1_arvalid = 1; m0_rready = 1; m1_rready = 1;
    s_arready = 1; s_rvalid = 1; s_rlast = 1; s_rdata = '1; s_rresp = 2'b11; s_rid = '0;
    #1;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs_async: got %h want 0", all_out);
    end
    tick();
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs_held: got %h want 0", all_out);
    end
    clear_inputs();
    reset_n = 1;
    #1;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_idle_outputs: got %h want 0", all_out);
    end
    m0_arvalid = 1; s_arready = 1; s_rvalid = 1; m0_rready = 1;
    #1;
    n_checks++;
    if ({s_arvalid, m0_arready, s_rready, m0_rvalid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_no_handshake: got %b want 0000", {s_arvalid, m0_arready, s_rready, m0_rvalid});
    end
    clear_inputs();
  endtask

  task automatic test_single_m0;
    req0(32'hA000_0010, 8'd3, 4'h5);
    #1;
    n_checks++;
    if (s_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL single_latency: s_arvalid got %b want 0", s_arvalid);
    end
    tick();
    n_checks++;
    if ({s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid} !==
        {1'b1, 32'hA000_0010, 8'd3, 3'd2, BURST_INCR, 4'h0}) begin
      n_fail++;
      $display("FAIL single_ar_fwd: got v=%b a=%h l=%0d s=%0d b=%0d id=%h want v=1 a=a0000010 l=3 s=2 b=1 id=0",
               s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid);
    end
    s_arready = 1;
    #1;
    n_checks++;
    if ({m0_arready, m1_arready} !== 2'b10) begin
      n_fail++; $display("FAIL single_arready: got %b want 10", {m0_arready, m1_arready});
    end
    tick();
    m0_arvalid = 0; s_arready = 0;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1; s_rdata = 32'(17 * (i + 1)); s_rlast = (i == 3); s_rid = '0; s_rresp = RESP_OKAY;
      #1;
      n_checks++;
      if ({m0_rvalid, m1_rvalid, s_rready, m0_rlast} !== {1'b1, 1'b0, 1'b1, (i == 3)}) begin
        n_fail++;
        $display("FAIL single_beat_ctl[%0d]: got %b want %b", i,
                 {m0_rvalid, m1_rvalid, s_rready, m0_rlast}, {1'b1, 1'b0, 1'b1, (i == 3)});
      end
      n_checks++;
      if ({m0_rdata, m0_rid, m0_rresp} !== {32'(17 * (i + 1)), 4'h5, RESP_OKAY}) begin
        n_fail++;
        $display("FAIL single_beat_data[%0d]: got d=%h id=%h r=%b want d=%h id=5 r=00", i,
                 m0_rdata, m0_rid, m0_rresp, 32'(17 * (i + 1)));
      end
      tick();
    end
    s_rvalid = 1; s_rlast = 1; s_rdata = 32'hDEAD;
    #1;
    n_checks++;
    if ({m0_rvalid, s_rready, m0_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL single_idle_after_last: got rv=%b rr=%b d=%h want 0 0 0", m0_rvalid, s_rready, m0_rdata);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin;
    logic g;
    apply_reset();
    req0(32'h1000, 8'd0, 4'h2);
    req1(32'h2000, 8'd0, 4'h7);
    for (int k = 0; k < 3; k++) begin
      g = 1'(k % 2);
      #1;
      n_checks++;
      if (s_arvalid !== 1'b0) begin
        n_fail++; $display("FAIL rr_bubble[%0d]: s_arvalid got %b want 0", k, s_arvalid);
      end
      tick();
      n_checks++;
      if ({s_arvalid, s_arid, s_araddr} !== {1'b1, {3'b000, g}, (g ? 32'h2000 : 32'h1000)}) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got v=%b id=%h a=%h want v=1 id=%h", k, s_arvalid, s_arid, s_araddr, g);
      end
      s_arready = 1;
      #1;
      n_checks++;
      if ({m0_arready, m1_arready} !== {~g, g}) begin
        n_fail++; $display("FAIL rr_arready[%0d]: got %b want %b", k, {m0_arready, m1_arready}, {~g, g});
      end
      tick();
      s_arready = 0; s_rvalid = 1; s_rlast = 1; s_rdata = k; s_rid = {3'b000, g};
      #1;
      n_checks++;
      if ({m0_rvalid, m1_rvalid, (g ? m1_rid : m0_rid)} !== {~g, g, (g ? 4'h7 : 4'h2)}) begin
        n_fail++;
        $display("FAIL rr_route[%0d]: got rv=%b%b rid0=%h rid1=%h want grant %b", k,
                 m0_rvalid, m1_rvalid, m0_rid, m1_rid, g);
      end
      tick();
      s_rvalid = 0; s_rlast = 0;
    end
    clear_inputs();
  endtask

  task automatic test_pending_request;
    req0(32'h3000, 8'd1, 4'h1);
    tick();
    s_arready = 1;
    tick();
    s_arready = 0; m0_arvalid = 0;
    req1(32'h4000, 8'd0, 4'h3);
    for (int i = 0; i < 2; i++) begin
      s_rvalid = 1; s_rlast = (i == 1); s_rid = '0; s_rdata = i;
      #1;
      n_checks++;
      if ({m1_arready, s_arvalid, m1_rvalid, m0_rvalid} !== 4'b0001) begin
        n_fail++;
        $display("FAIL pend_blocked[%0d]: got %b want 0001", i, {m1_arready, s_arvalid, m1_rvalid, m0_rvalid});
      end
      tick();
    end
    s_rvalid = 0; s_rlast = 0; s_arready = 1;
    #1;
    n_checks++;
    if ({s_arvalid, m1_arready} !== 2'b00) begin
      n_fail++; $display("FAIL pend_bubble: got %b want 00", {s_arvalid, m1_arready});
    end
    tick();
    n_checks++;
    if ({s_arvalid, s_arid, s_araddr, m1_arready} !== {1'b1, 4'h1, 32'h4000, 1'b1}) begin
      n_fail++;
      $display("FAIL pend_grant: got v=%b id=%h a=%h rdy=%b want 1 1 4000 1", s_arvalid, s_arid, s_araddr, m1_arready);
    end
    tick();
    s_arready = 0; m1_arvalid = 0; s_rvalid = 1; s_rlast = 1; s_rid = 4'h1; s_rdata = 32'h77;
    #1;
    n_checks++;
    if ({m1_rvalid, m1_rid, m1_rdata, m0_rvalid} !== {1'b1, 4'h3, 32'h77, 1'b0}) begin
      n_fail++;
      $display("FAIL pend_m1_beat: got rv=%b id=%h d=%h rv0=%b want 1 3 77 0", m1_rvalid, m1_rid, m1_rdata, m0_rvalid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_rready_stall;
    int pat[6] = '{1, 0, 0, 0, 1, 1};
    int idx = 0;
    int nrecv = 0;
    logic [31:0] recv[4];
    for (int j = 0; j < 4; j++) recv[j] = '0;
    req0(32'h5000, 8'd2, 4'h6);
    tick();
    s_arready = 1;
    tick();
    s_arready = 0; m0_arvalid = 0;
    for (int c = 0; c < 6; c++) begin
      m0_rready = pat[c][0]; s_rvalid = 1; s_rdata = 32'hA1 + idx; s_rlast = (idx == 2);
      #1;
      n_checks++;
      if ({s_rready, m0_rvalid} !== {pat[c][0], 1'b1}) begin
        n_fail++; $display("FAIL stall_rready[%0d]: got %b want %b1", c, {s_rready, m0_rvalid}, pat[c][0]);
      end
      if (m0_rvalid && m0_rready) begin
        if (nrecv < 4) recv[nrecv] = m0_rdata;
        nrecv++;
      end
      if (s_rready) idx++;
      tick();
    end
    s_rvalid = 0; s_rlast = 0;
    n_checks++;
    if ({nrecv[7:0], recv[0], recv[1], recv[2]} !== {8'd3, 32'hA1, 32'hA2, 32'hA3}) begin
      n_fail++;
      $display("FAIL stall_beats: got n=%0d %h %h %h want 3 a1 a2 a3", nrecv, recv[0], recv[1], recv[2]);
    end
    s_rvalid = 1; s_rlast = 1;
    #1;
    n_checks++;
    if ({s_rready, m0_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL stall_idle_after: got %b want 00", {s_rready, m0_rvalid});
    end
    clear_inputs();
  endtask

  task automatic test_rid_mismatch;
    req0(32'h6000, 8'd1, 4'h4);
    tick();
    s_arready = 1;
    tick();
    s_arready = 0; m0_arvalid = 0;
    s_rvalid = 1; s_rid = 4'h1; s_rresp = RESP_OKAY; s_rdata = 32'h55; s_rlast = 0;
    #1;
    n_checks++;
    if ({m0_rvalid, m0_rresp, m0_rdata, m0_rid, s_rready} !== {1'b1, RESP_SLVERR, 32'h55, 4'h4, 1'b1}) begin
      n_fail++;
      $display("FAIL rid_bad_beat: got rv=%b resp=%b d=%h id=%h rr=%b want 1 10 55 4 1",
               m0_rvalid, m0_rresp, m0_rdata, m0_rid, s_rready);
    end
    tick();
    s_rid = 4'h2; s_rdata = 32'h66; s_rlast = 1;
    #1;
    n_checks++;
    if ({m0_rvalid, m0_rresp, m0_rdata, m0_rlast} !== {1'b1, RESP_OKAY, 32'h66, 1'b1}) begin
      n_fail++;
      $display("FAIL rid_good_beat: got rv=%b resp=%b d=%h last=%b want 1 00 66 1", m0_rvalid, m0_rresp, m0_rdata, m0_rlast);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst;
    req0(32'h7000, 8'd3, 4'h5);
    tick();
    s_arready = 1;
    tick();
    s_arready = 0; m0_arvalid = 0;
    for (int i = 0; i < 2; i++) begin
      s_rvalid = 1; s_rdata = i; s_rlast = 0;
      tick();
    end
    s_rvalid = 1; s_rdata = 32'h3;
    #1;
    n_checks++;
    if (m0_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: m0_rvalid got %b want 1", m0_rvalid);
    end
    #2;
    reset_n = 0;
    #1;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL midrst_async_outputs: got %h want 0", all_out);
    end
    clear_inputs();
    tick();
    tick();
    reset_n = 1;
    s_rvalid = 1; s_rlast = 1; m0_rready = 1; m1_rready = 1;
    #1;
    n_checks++;
    if ({m0_rvalid, m1_rvalid, s_rready} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_no_beat: got %b want 000", {m0_rvalid, m1_rvalid, s_rready});
    end
    s_rvalid = 0; s_rlast = 0;
    req1(32'hB000_0000, 8'd0, 4'h9);
    tick();
    n_checks++;
    if ({s_arvalid, s_arid, s_araddr} !== {1'b1, 4'h1, 32'hB000_0000}) begin
      n_fail++; $display("FAIL midrst_m1_grant: got v=%b id=%h a=%h want 1 1 b0000000", s_arvalid, s_arid, s_araddr);
    end
    s_arready = 1;
    tick();
    s_arready = 0; m1_arvalid = 0; s_rvalid = 1; s_rlast = 1; s_rid = 4'h1; s_rdata = 32'h99;
    #1;
    n_checks++;
    if ({m1_rvalid, m1_rid, m1_rdata, m1_rresp, m0_rvalid} !== {1'b1, 4'h9, 32'h99, RESP_OKAY, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_m1_beat: got rv=%b id=%h d=%h resp=%b rv0=%b want 1 9 99 00 0",
               m1_rvalid, m1_rid, m1_rdata, m1_rresp, m0_rvalid);
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    reset_n = 0;
    clear_inputs();
    tick();
    test_reset();
    test_single_m0();
    test_round_robin();
    test_pending_request();
    test_rready_stall();
    test_rid_mismatch();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25010030_axi_rd_arbiter.md
# ysyx_25010030_axi_rd_arbiter

Two-master AXI4 read-channel arbiter that shares the single SoC read port between the instruction cache (m0) and the load/store unit (m1). Sits between both fetch/load requesters and the crossbar/SoC master port. Grants one whole burst at a time, locks the grant until the last beat, and alternates grants round-robin under contention. Write channels do not pass through this block.

## Interface
- `ID_W`, default 4: AXI ID width on all ports.
- `DATA_W`, default 32: read data width.
- `clk  in  1`: single clock.
- `reset_n  in  1`: reset, asynchronous and active-low.
- `m0_araddr / m1_araddr  in  32`: requester read address.
- `m0_arvalid / m1_arvalid  in  1`: request valid.
- `m0_arready / m1_arready  out  1`: request accepted.
- `m0_arid / m1_arid  in  ID_W`: requester ID, echoed on its `rid`.
- `m0_arlen, m0_arsize, m0_arburst / m1_*  in  8, 3, 2`: burst attributes, forwarded unchanged.
- `m0_rvalid / m1_rvalid  out  1`: beat valid to requester.
- `m0_rready / m1_rready  in  1`: requester accepts beat.
- `m0_rdata, m0_rresp, m0_rid, m0_rlast / m1_*  out  DATA_W, 2, ID_W, 1`: routed beat.
- `s_araddr, s_arlen, s_arsize, s_arburst  out  32, 8, 3, 2`: to slave.
- `s_arvalid  out  1` / `s_arready  in  1`.
- `s_arid  out  ID_W`: `{ {ID_W-1{1'b0}}, grant }`.
- `s_rvalid, s_rdata, s_rresp, s_rid, s_rlast  in  1, DATA_W, 2, ID_W, 1`.
- `s_rready  out  1`.

## Operation
- State register: IDLE, ADDR, DATA. Registers: `grant` (0=m0, 1=m1), `last_grant`, `saved_id` (ID_W).
- IDLE: no handshakes are possible. All `*_arready`, `s_arvalid`, `s_rready`, and `m*_rvalid` are 0.
  - One request valid: grant that requester.
  - Both valid: grant `~last_grant`.
  - On a grant, capture the granted `arid` into `saved_id` and move to ADDR.
- ADDR:
  - `s_ar*` is driven combinationally from the granted master.
  - `s_arvalid = m[grant]_arvalid`, `m[grant]_arready = s_arready`. The other master's `arready` is 0.
  - On the `s_arvalid & s_arready` handshake, move to DATA.
  - If the granted master drops `arvalid`, the block stays in ADDR. No regrant occurs.
- DATA:
  - `m[grant]_rvalid = s_rvalid`, `s_rready = m[grant]_rready`.
  - `m[grant]_rdata / rlast` come from the slave. `m[grant]_rid = saved_id`.
  - The other master's `rvalid` is 0.
  - On `s_rvalid & s_rready & s_rlast`: set `last_grant <= grant` and return to IDLE.
- ID check: if `s_rid[0] != grant` on a beat, the routed `rresp` is forced to 2'b10 (SLVERR). Data is still routed and the beat is still consumed.
- Non-granted outputs `rdata / rresp / rlast / rid` are driven 0.
- A request arriving mid-burst waits; its `arready` stays 0 until a later grant.

## Timing
- Reset (asynchronous assertion, synchronous release): state IDLE, `grant` 0, `last_grant` 1 (m0 wins the first tie), `saved_id` 0. All outputs 0.
- Request-to-`s_arvalid` latency: 1 cycle. `arvalid` seen in IDLE at edge N gives `s_arvalid` in cycle N+1.
- Last beat accepted at edge N: IDLE in cycle N+1, next grant at edge N+1, next `s_arvalid` in cycle N+2. This is one bubble cycle between bursts.
- Single-beat (`arlen`=0) bursts follow the same flow; the first beat must carry `rlast`.
- `s_rvalid` while in IDLE or ADDR is ignored (`s_rready` 0).
- Reset mid-burst: the transaction is abandoned and no beat is forwarded after reset. The slave is reset by the same `reset_n`.
- All AR/R forwarding is combinational. There is no extra buffering and no throughput loss within a burst.

## Structure
- Shared package `ysyx_25010030_axi_pkg` holds the state encoding (IDLE=2'b00, ADDR=2'b01, DATA=2'b10), `RESP_OKAY`/`RESP_SLVERR`, and `BURST_INCR`.
- One sub-module, `ysyx_25010030_rr_arb2`: a 2-way round-robin pick from two valids plus `last_grant`. It is purely combinational and reusable for a future write arbiter.
- State/grant registers and muxing stay in the top.

## Test plan
- m0 alone, `araddr` 0xA000_0010, `arlen` 3, slave beats 0x11..0x44 with `rlast` on the 4th:
  - m0 gets 4 beats with `m0_rid = m0_arid`.
  - `m1_rvalid` stays 0.
  - IDLE is reached 1 cycle after the last beat.
- m0 and m1 both assert right after reset: m0 is granted first, then m1, then m0 again. `s_arid` goes 0, 1, 0.
- m1 asserts `arvalid` during m0's burst: `m1_arready` stays 0 until m0's `rlast` handshake. `s_arvalid` for m1 rises exactly 2 cycles after it.
- Granted master holds `rready` = 0 for 3 cycles mid-burst: `s_rready` = 0 for those cycles, and no beats are lost or duplicated.
- Slave returns `s_rid` = 1 while m0 is granted: `m0_rresp` = 2'b10 for that beat and the data is still delivered.
- `reset_n` low during DATA beat 2: all outputs are 0 asynchronously. After release, a fresh m1 request is granted normally.
